// File: rtl/example.sv
// example: registered six-input gate network Y = NAND(NAND(A,B), AND(C,~B,D), NOR(E,F)),
//          with a saturating count of valid results where Y=0.
// Latency: STAGES (1 or 2) clocks from input sample to Y/out_valid; one result per cycle.
// Backpressure: none; every valid sample is accepted and produces exactly one out_valid pulse.
//
// Optional feature macro: EXAMPLE_TERMS_EN (adds the registered terms[2:0] = {t3,t2,t1} output).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     qualifies A..F on this edge
//   A..F         term inputs
//   Y            registered result, idles at 1, changes only with out_valid
//   out_valid    Y holds a new result this cycle
//   y_low_count  saturating count of valid results with Y=0
//   terms        (EXAMPLE_TERMS_EN only) registered {t3,t2,t1}, resets to 3'b101

module example #(
   parameter int STAGES  = 1,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               A,
   input  logic               B,
   input  logic               C,
   input  logic               D,
   input  logic               E,
   input  logic               F,
   output logic               Y,
   output logic               out_valid,
   output logic [COUNT_W-1:0] y_low_count
`ifdef EXAMPLE_TERMS_EN
   ,
   output logic [2:0]         terms
`endif
);

   // Parameter legality is checked at elaboration.
   if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
      $error("example: STAGES must be 1 or 2, got %0d", STAGES);
   end
   if (COUNT_W < 1) begin : g_bad_count_w
      $error("example: COUNT_W must be at least 1, got %0d", COUNT_W);
   end

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   // Sample seen by the evaluation stage, packed as {A,B,C,D,E,F}.
   logic       ev_valid;
   logic [5:0] ev_dat;

   if (STAGES == 2) begin : g_stage2
      logic       s1_valid;
      logic [5:0] s1_dat;

      // Data is captured only with in_valid so unqualified (possibly X) inputs never
      // enter the pipeline. The all-zero reset value evaluates to Y=1.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_dat   <= 6'b000000;
         end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_dat <= {A, B, C, D, E, F};
            end
         end
      end

      assign ev_valid = s1_valid;
      assign ev_dat   = s1_dat;
   end else begin : g_stage1
      assign ev_valid = in_valid;
      assign ev_dat   = {A, B, C, D, E, F};
   end

   // Gate network on the evaluation-stage sample.
   logic t1;
   logic t2;
   logic t3;
   logic y_next;

   always_comb begin
      t1     = ~(ev_dat[5] & ev_dat[4]);
      t2     = ev_dat[3] & ~ev_dat[4] & ev_dat[2];
      t3     = ~(ev_dat[1] | ev_dat[0]);
      y_next = ~(t1 & t2 & t3);
   end

   // Output stage: Y (and terms) only move on a valid result, otherwise they hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Y         <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         out_valid <= ev_valid;
         if (ev_valid) begin
            Y <= y_next;
         end
      end
   end

`ifdef EXAMPLE_TERMS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         terms <= 3'b101;
      end else if (ev_valid) begin
         terms <= {t3, t2, t1};
      end
   end
`endif

   // Saturating count of valid Y=0 results; never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_low_count <= '0;
      end else if (ev_valid && !y_next && (y_low_count != CNT_MAX)) begin
         y_low_count <= y_low_count + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_example.sv
// tb_example: self-checking bench for example.
// Three instances share one stimulus stream: STAGES=1/COUNT_W=8, STAGES=1/COUNT_W=2,
// STAGES=2/COUNT_W=8; each is compared against a per-instance reference model.

module tb_example;

   logic clk;
   logic rst_n;
   logic in_valid;
   logic A, B, C, D, E, F;

   logic       y_a, ov_a;
   logic [7:0] cnt_a;
   logic       y_s, ov_s;
   logic [1:0] cnt_s;
   logic       y_b, ov_b;
   logic [7:0] cnt_b;
`ifdef EXAMPLE_TERMS_EN
   logic [2:0] terms_a, terms_s, terms_b;
`endif

   int total;
   int bad;

   example #(.STAGES(1), .COUNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
      .Y(y_a), .out_valid(ov_a), .y_low_count(cnt_a)
`ifdef EXAMPLE_TERMS_EN
      , .terms(terms_a)
`endif
   );

   example #(.STAGES(1), .COUNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
      .Y(y_s), .out_valid(ov_s), .y_low_count(cnt_s)
`ifdef EXAMPLE_TERMS_EN
      , .terms(terms_s)
`endif
   );

   example #(.STAGES(2), .COUNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
      .Y(y_b), .out_valid(ov_b), .y_low_count(cnt_b)
`ifdef EXAMPLE_TERMS_EN
      , .terms(terms_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Inputs are packed {A,B,C,D,E,F}. Y is 0 only for B=0,C=1,D=1,E=0,F=0.
   function automatic logic ref_y(input logic [5:0] s);
      return !(s[4] == 1'b0 && s[3] == 1'b1 && s[2] == 1'b1 && s[1] == 1'b0 && s[0] == 1'b0);
   endfunction

   function automatic logic [2:0] ref_terms(input logic [5:0] s);
      logic t1, t2, t3;
      t1 = !(s[5] && s[4]);
      t2 = s[3] && !s[4] && s[2];
      t3 = !(s[1] || s[0]);
      return {t3, t2, t1};
   endfunction

   // index 0 = dut_a, 1 = dut_s, 2 = dut_b
   logic       m_y    [3];
   logic       m_ov   [3];
   int         m_cnt  [3];
   logic [2:0] m_terms[3];
   int         m_lim  [3];
   logic       pend_v;
   logic [5:0] pend_s;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_y[i]     = 1'b1;
         m_ov[i]    = 1'b0;
         m_cnt[i]   = 0;
         m_terms[i] = 3'b101;
      end
      pend_v = 1'b0;
      pend_s = 6'b0;
   endtask

   task automatic model_apply(input int i, input logic v, input logic [5:0] s);
      m_ov[i] = v;
      if (v) begin
         m_y[i]     = ref_y(s);
         m_terms[i] = ref_terms(s);
         if (!m_y[i] && m_cnt[i] < m_lim[i]) m_cnt[i]++;
      end
   endtask

   task automatic model_edge(input logic v, input logic [5:0] s);
      model_apply(0, v, s);
      model_apply(1, v, s);
      model_apply(2, pend_v, pend_s);   // two-stage instance sees last cycle's sample
      pend_v = v;
      pend_s = s;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      check("a_y",   int'(y_a),   int'(m_y[0]));
      check("a_ov",  int'(ov_a),  int'(m_ov[0]));
      check("a_cnt", int'(cnt_a), m_cnt[0]);
      check("s_y",   int'(y_s),   int'(m_y[1]));
      check("s_ov",  int'(ov_s),  int'(m_ov[1]));
      check("s_cnt", int'(cnt_s), m_cnt[1]);
      check("b_y",   int'(y_b),   int'(m_y[2]));
      check("b_ov",  int'(ov_b),  int'(m_ov[2]));
      check("b_cnt", int'(cnt_b), m_cnt[2]);
`ifdef EXAMPLE_TERMS_EN
      check("a_terms", int'(terms_a), int'(m_terms[0]));
      check("s_terms", int'(terms_s), int'(m_terms[1]));
      check("b_terms", int'(terms_b), int'(m_terms[2]));
`endif
   endtask

   // Drive one sample, take the edge, compare all instances 1 ns later.
   task automatic tick(input logic v, input logic [5:0] s);
      in_valid = v;
      {A, B, C, D, E, F} = s;
      @(posedge clk);
      model_edge(v, s);
      #1;
      check_all();
   endtask

   // Reset asserted mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic       v;
      logic [5:0] s;
      logic       y;
      logic       ov;
      int         cnt;
   } vec_t;

   vec_t tbl[7];
   int   sat_exp[5];
   int   zeros;
   logic [5:0] rs;

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      {A, B, C, D, E, F} = 6'b0;
      m_lim[0] = 255;
      m_lim[1] = 3;
      m_lim[2] = 255;
      model_reset();

      //            v     {ABCDEF}    Y     ov    cnt
      tbl[0] = '{1'b1, 6'b100100, 1'b1, 1'b1, 0};
      tbl[1] = '{1'b1, 6'b001100, 1'b0, 1'b1, 1};
      tbl[2] = '{1'b1, 6'b100100, 1'b1, 1'b1, 1};
      tbl[3] = '{1'b1, 6'b100101, 1'b1, 1'b1, 1};
      tbl[4] = '{1'b0, 6'b001100, 1'b1, 1'b0, 1};
      tbl[5] = '{1'b1, 6'b001100, 1'b0, 1'b1, 2};
      tbl[6] = '{1'b0, 6'b100100, 1'b0, 1'b0, 2};
      sat_exp = '{1, 2, 3, 3, 3};

      do_reset();

      // Directed single-stage sequence, including gaps where Y must hold.
      for (int k = 0; k < 7; k++) begin
         tick(tbl[k].v, tbl[k].s);
         check($sformatf("tbl%0d_y", k),   int'(y_a),   int'(tbl[k].y));
         check($sformatf("tbl%0d_ov", k),  int'(ov_a),  int'(tbl[k].ov));
         check($sformatf("tbl%0d_cnt", k), int'(cnt_a), tbl[k].cnt);
      end

      // Unqualified X inputs must not disturb Y or the counters.
      in_valid = 1'b0;
      {A, B, C, D, E, F} = 6'bxxxxxx;
      @(posedge clk);
      model_edge(1'b0, 6'b0);
      #1;
      check_all();
      tick(1'b0, 6'b0);

      // Mid-cycle reset with non-idle state (Y=0, count=2).
      do_reset();

      // Exhaustive sweep, back-to-back.
      zeros = 0;
      for (int c = 0; c < 64; c++) begin
         tick(1'b1, 6'(c));
         if (y_a == 1'b0) zeros++;
      end
      tick(1'b0, 6'b0);
      check("sweep_zero_codes", zeros, 2);
      check("sweep_cnt_a", int'(cnt_a), 2);
      check("sweep_cnt_b", int'(cnt_b), 2);

      // Saturation on the COUNT_W=2 instance.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         tick(1'b1, 6'b001100);
         check($sformatf("sat%0d", k), int'(cnt_s), sat_exp[k]);
      end

      // Two-stage latency.
      do_reset();
      tick(1'b1, 6'b001100);
      check("s2_lat1_ov", int'(ov_b), 0);
      check("s2_lat1_y",  int'(y_b),  1);
      tick(1'b0, 6'b0);
      check("s2_lat2_ov", int'(ov_b), 1);
      check("s2_lat2_y",  int'(y_b),  0);
`ifdef EXAMPLE_TERMS_EN
      check("s2_lat2_terms", int'(terms_b), 7);
`endif
      tick(1'b0, 6'b0);
      check("s2_lat3_ov", int'(ov_b), 0);

      // Reset while a sample is in flight in the two-stage instance.
      tick(1'b1, 6'b001100);
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      model_reset();
      check("flight_ov",  int'(ov_b), 0);
      check("flight_y",   int'(y_b),  1);
`ifdef EXAMPLE_TERMS_EN
      check("flight_terms", int'(terms_b), 5);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick(1'b0, 6'b0);
      check("flight_post1_ov", int'(ov_b), 0);
      tick(1'b0, 6'b0);
      check("flight_post2_ov", int'(ov_b), 0);

      // Randomized traffic, biased toward the Y=0 code.
      for (int k = 0; k < 400; k++) begin
         rs = 6'($urandom);
         if ($urandom_range(0, 3) == 0) rs = {rs[5], 5'b01100};
         tick($urandom_range(0, 3) != 0, rs);
      end
      tick(1'b0, 6'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
